// File: rtl/control_fsm.sv
// control_fsm
//   Multicycle sequencer in front of the instruction decoder. Fetches a
//   16-bit instruction into instr_reg, lets the decoder classify it, then
//   walks through execute / load / store / write-back while driving the
//   register-file, flag and memory strobes. Owns the program counter.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   mem_rdata         memory read data (instruction or load data)
//   mem_ready         memory completes the current access this cycle
//   instr_type        decoder class: 00 R/imm, 01 STORE, 10 LOAD, 11 illegal
//   instruction_out   decoder ALU opcode
//   instr_reg         instruction register (to decoder instruction_in)
//   pc                program counter, wraps modulo 2^ADDR_W
//   load_data         data captured by LOAD
//   mem_addr_sel      0 = address from pc, 1 = address from register operand
//   mem_re, mem_we    memory read / write strobes
//   reg_we, flag_we   register-file / flag write enables
//   load_sel          write-back mux: 1 = load_data, 0 = ALU result
//   state             current state encoding (debug)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | post-reset bubble, no strobes
// FETCH  | read instruction at pc, wait for mem_ready
// DECODE | decoder settles on instr_reg, branch on type
// EXEC   | ALU op: register and/or flag write
// LOAD   | read data at operand address, wait for ready
// WB     | write load_data into the register file
// STORE  | write data at operand address, wait for ready

module control_fsm #(
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [1:0]        instr_type,
  input  logic [7:0]        instruction_out,
  output logic [15:0]       instr_reg,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       load_data,
  output logic              mem_addr_sel,
  output logic              mem_re,
  output logic              mem_we,
  output logic              reg_we,
  output logic              flag_we,
  output logic              load_sel,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    LOAD   = 3'd4,
    WB     = 3'd5,
    STORE  = 3'd6
  } state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;

  state_t state_q;
  state_t state_d;

  logic fetch_done;
  logic load_done;

  assign fetch_done = (state_q == FETCH) && mem_ready;
  assign load_done  = (state_q == LOAD)  && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= 16'h0000;
      pc        <= RESET_PC;
    end else if (fetch_done) begin
      instr_reg <= mem_rdata;
      pc        <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data <= 16'h0000;
    end else if (load_done) begin
      load_data <= mem_rdata;
    end
  end

  // Next-state logic. mem_ready is only consulted in the memory states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (instr_type)
          2'b00:   state_d = EXEC;
          2'b01:   state_d = STORE;
          2'b10:   state_d = LOAD;
          default: state_d = FETCH;   // illegal: behaves as a NOP
        endcase
      end
      EXEC:    state_d = FETCH;
      LOAD:    if (mem_ready) state_d = WB;
      WB:      state_d = FETCH;
      STORE:   if (mem_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobes: decoded only from the registered state (plus the
  // decoder opcode in EXEC), so mem_ready never reaches a strobe.
  always_comb begin
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    flag_we      = 1'b0;
    load_sel     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_re = 1'b1;
      end
      EXEC: begin
        reg_we  = (instruction_out != OP_CMP) && (instruction_out != OP_NOP);
        flag_we = (instruction_out == OP_ADD) || (instruction_out == OP_SUB) ||
                  (instruction_out == OP_CMP);
      end
      LOAD: begin
        mem_re       = 1'b1;
        mem_addr_sel = 1'b1;
      end
      WB: begin
        reg_we   = 1'b1;
        load_sel = 1'b1;
      end
      STORE: begin
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [1:0]  instr_type = 2'b00;
  logic [7:0]  instruction_out = 8'h00;

  logic [15:0] instr_reg, load_data;
  logic [15:0] pc;
  logic        mem_addr_sel, mem_re, mem_we, reg_we, flag_we, load_sel;
  logic [2:0]  state;

  logic [15:0] instr_reg_w, load_data_w;
  logic [3:0]  pc_w;
  logic        mem_addr_sel_w, mem_re_w, mem_we_w, reg_we_w, flag_we_w, load_sel_w;
  logic [2:0]  state_w;

  always #5 clk = ~clk;

  control_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr_type(instr_type), .instruction_out(instruction_out),
    .instr_reg(instr_reg), .pc(pc), .load_data(load_data),
    .mem_addr_sel(mem_addr_sel), .mem_re(mem_re), .mem_we(mem_we),
    .reg_we(reg_we), .flag_we(flag_we), .load_sel(load_sel), .state(state)
  );

  control_fsm #(.ADDR_W(4), .RESET_PC(4'hF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr_type(instr_type), .instruction_out(instruction_out),
    .instr_reg(instr_reg_w), .pc(pc_w), .load_data(load_data_w),
    .mem_addr_sel(mem_addr_sel_w), .mem_re(mem_re_w), .mem_we(mem_we_w),
    .reg_we(reg_we_w), .flag_we(flag_we_w), .load_sel(load_sel_w), .state(state_w)
  );

  // One expected cycle: stimulus for that cycle plus the observation
  // {state, mem_re, mem_we, mem_addr_sel, reg_we, flag_we, load_sel}.
  typedef struct packed {
    logic        rdy;
    logic [15:0] rdata;
    logic [1:0]  itype;
    logic [7:0]  op;
    logic [8:0]  exp;
  } cyc_t;

  cyc_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [3:0]  m_pcw = 4'hF;
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_ld = 16'h0000;

  task automatic push_cyc(input logic rdy, input logic [15:0] rdata, input logic [1:0] it,
                          input logic [7:0] op, input logic [8:0] exp);
    cyc_t c;
    c.rdy = rdy; c.rdata = rdata; c.itype = it; c.op = op; c.exp = exp;
    q.push_back(c);
  endtask

  // Expected cycle sequence of one instruction from the architectural rules:
  // fetch with waits, one decode cycle, then the per-class tail.
  task automatic model_instr(input logic [15:0] word, input logic [1:0] it, input logic [7:0] op,
                             input int fw, input int mw, input logic [15:0] ld);
    logic rwe, fwe;
    for (int i = 0; i < fw; i++) push_cyc(1'b0, 16'($urandom), it, op, {3'd1, 6'b100000});
    push_cyc(1'b1, word, it, op, {3'd1, 6'b100000});
    m_ir  = word;
    m_pc  = m_pc + 16'd1;
    m_pcw = m_pcw + 4'd1;
    push_cyc(1'($urandom), 16'($urandom), it, op, {3'd2, 6'b000000});
    case (it)
      2'b00: begin
        rwe = !(op == 8'h0B || op == 8'h00);
        fwe = (op == 8'h05 || op == 8'h09 || op == 8'h0B);
        push_cyc(1'($urandom), 16'($urandom), it, op, {3'd3, 3'b000, rwe, fwe, 1'b0});
      end
      2'b01: begin
        for (int i = 0; i < mw; i++) push_cyc(1'b0, 16'($urandom), it, op, {3'd6, 6'b011000});
        push_cyc(1'b1, 16'($urandom), it, op, {3'd6, 6'b011000});
      end
      2'b10: begin
        for (int i = 0; i < mw; i++) push_cyc(1'b0, 16'($urandom), it, op, {3'd4, 6'b101000});
        push_cyc(1'b1, ld, it, op, {3'd4, 6'b101000});
        m_ld = ld;
        push_cyc(1'($urandom), 16'($urandom), it, op, {3'd5, 6'b000101});
      end
      default: ;
    endcase
  endtask

  // Drain up to n queued cycles: check outputs at the falling edge, then
  // apply that cycle's inputs for the next rising edge.
  task automatic play(input string name, input int n);
    cyc_t c;
    logic [8:0] act;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk);
      act = {state, mem_re, mem_we, mem_addr_sel, reg_we, flag_we, load_sel};
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s cyc%0d: state/strobes got %b want %b", name, k, act, c.exp);
      end
      mem_ready = c.rdy; mem_rdata = c.rdata; instr_type = c.itype; instruction_out = c.op;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 16'h0000; m_pcw = 4'hF; m_ir = 16'h0000; m_ld = 16'h0000;
    q.delete();
    push_cyc(1'($urandom), 16'($urandom), 2'b00, 8'h00, {3'd0, 6'b000000});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({state, mem_re, mem_we, mem_addr_sel, reg_we, flag_we, load_sel} !== 9'd0 ||
        pc !== 16'h0000 || instr_reg !== 16'h0000 || load_data !== 16'h0000 || pc_w !== 4'hF) begin
      bad++;
      $display("FAIL reset_values: state=%0d pc=%h ir=%h ld=%h pcw=%h want all 0, pcw=f",
               state, pc, instr_reg, load_data, pc_w);
    end
    release_reset();
    model_instr(16'h4123, 2'b01, 8'h00, 0, 5, 16'h0000);
    play("reset_store", 4);          // IDLE, FETCH, DECODE, first STORE cycle
    #2;
    total++;
    if (mem_we !== 1'b1 || state !== 3'd6) begin
      bad++;
      $display("FAIL reset_prestore: mem_we=%b state=%0d want 1,6", mem_we, state);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || state !== 3'd0 || pc !== 16'h0000 || instr_reg !== 16'h0000 ||
        pc_w !== 4'hF) begin
      bad++;
      $display("FAIL reset_async: mem_we=%b state=%0d pc=%h ir=%h pcw=%h want 0,0,0,0,f",
               mem_we, state, pc, instr_reg, pc_w);
    end
    release_reset();
    model_instr(16'h0000, 2'b11, 8'h00, 0, 0, 16'h0000);
    play("reset_restart", 1000);
    total++;
    if (pc !== m_pc || pc_w !== 4'h0 || instr_reg_w !== m_ir) begin
      bad++;
      $display("FAIL pc_wrap: pc=%h pcw=%h irw=%h want %h,0,%h", pc, pc_w, instr_reg_w, m_pc, m_ir);
    end
  endtask

  task automatic test_add();
    model_instr(16'h0251, 2'b00, 8'h05, 0, 0, 16'h0000);
    play("add", 1000);
    total++;
    if (pc !== m_pc || instr_reg !== 16'h0251) begin
      bad++;
      $display("FAIL add_regs: pc=%h ir=%h want %h,0251", pc, instr_reg, m_pc);
    end
  endtask

  task automatic test_cmp();
    model_instr(16'h0B00, 2'b00, 8'h0B, 1, 0, 16'h0000);
    model_instr(16'h0000, 2'b00, 8'h00, 0, 0, 16'h0000);
    model_instr(16'h0911, 2'b00, 8'h09, 0, 0, 16'h0000);
    play("cmp", 1000);
    total++;
    if (pc !== m_pc || instr_reg !== m_ir) begin
      bad++;
      $display("FAIL cmp_regs: pc=%h ir=%h want %h,%h", pc, instr_reg, m_pc, m_ir);
    end
  endtask

  task automatic test_load_wait();
    model_instr(16'h8042, 2'b10, 8'h00, 0, 2, 16'hBEEF);
    play("load", 1000);
    total++;
    if (load_data !== 16'hBEEF || pc !== m_pc) begin
      bad++;
      $display("FAIL load_data: ld=%h pc=%h want beef,%h", load_data, pc, m_pc);
    end
  endtask

  task automatic test_store_illegal();
    model_instr(16'h4777, 2'b01, 8'h00, 0, 1, 16'h0000);
    model_instr(16'hC0DE, 2'b11, 8'h05, 2, 0, 16'h0000);
    play("store_illegal", 1000);
    total++;
    if (instr_reg !== 16'hC0DE || load_data !== m_ld || pc !== m_pc) begin
      bad++;
      $display("FAIL store_illegal_regs: ir=%h ld=%h pc=%h want c0de,%h,%h",
               instr_reg, load_data, pc, m_ld, m_pc);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [6];
    ops[0] = 8'h00; ops[1] = 8'h05; ops[2] = 8'h09; ops[3] = 8'h0B; ops[4] = 8'h01; ops[5] = 8'hFF;
    for (int n = 0; n < 60; n++) begin
      model_instr(16'($urandom), 2'($urandom), ops[$urandom_range(5, 0)],
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 16'($urandom));
      play("random", 1000);
      total++;
      if (pc !== m_pc || instr_reg !== m_ir || load_data !== m_ld ||
          pc_w !== m_pcw || instr_reg_w !== m_ir) begin
        bad++;
        $display("FAIL random_regs%0d: pc=%h ir=%h ld=%h pcw=%h want %h,%h,%h,%h",
                 n, pc, instr_reg, load_data, pc_w, m_pc, m_ir, m_ld, m_pcw);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) model_instr(16'(n * 16'h1111), 2'(n), 8'h05, 0, 0, 16'(16'hA000 + n));
    play("back_to_back", 1000);
    total++;
    if (pc !== m_pc || load_data !== m_ld) begin
      bad++;
      $display("FAIL b2b_regs: pc=%h ld=%h want %h,%h", pc, load_data, m_pc, m_ld);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_load_wait();
    test_store_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
